seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter c_REFRESH_LIMIT, default 100000, giving the DRIVE cycles per digit (1 ms at 100 MHz).
REQ-002 SHALL have parameter c_BLANK_LIMIT, default 1000, giving the all-anodes-off anti-ghost cycles before each digit.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 i_Clk  input  1  system clock; all logic on posedge.
REQ-005 i_Rst  input  1  synchronous active-high reset.
REQ-006 i_Load  input  1  single-cycle request to capture new display data.
REQ-007 i_Value  input  16  four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-008 i_Dp  input  4  decimal-point enables, one bit per digit.
REQ-009 i_Blank_Lz  input  1  leading-zero blanking enable.
REQ-010 o_Anode  output  4  active-low digit enables.
REQ-011 o_Segment  output  7  active-low {g,f,e,d,c,b,a}.
REQ-012 o_Dp  output  1  active-low decimal point.
REQ-013 o_Frame_Done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 SHALL use a two-state FSM, BLANK and DRIVE, plus a 2-bit digit index r_Digit and a terminal counter r_Count.
- BLANK lasts c_BLANK_LIMIT cycles, then moves to DRIVE.
- DRIVE lasts c_REFRESH_LIMIT cycles, then moves to BLANK.
- r_Count resets to 0 on every state change.
REQ-015 SHALL increment r_Digit on each DRIVE->BLANK transition, wrapping 3->0; frame period = 4*(c_BLANK_LIMIT+c_REFRESH_LIMIT) cycles.
REQ-016 SHALL, in BLANK, drive o_Anode=4'b1111, o_Segment=7'h7F and o_Dp=1.
REQ-017 SHALL, in DRIVE, drive only o_Anode[r_Digit] low, with the segments showing the decoded nibble r_Disp_Value[4*r_Digit+:4] and o_Dp = ~r_Disp_Dp[r_Digit].
REQ-018 SHALL register all outputs; no combinational path from any input to any output.
REQ-019 SHALL use the hex decode table 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110, with standard patterns for all other values 0-F.
REQ-020 SHALL, on i_Load=1, capture i_Value, i_Dp and i_Blank_Lz into pending registers and set r_Pending; a later load before the boundary overwrites the earlier one.
REQ-021 SHALL, at the frame boundary (the DRIVE->BLANK edge with r_Digit=3), copy the pending registers into the display registers when r_Pending=1 and clear r_Pending; display data never changes mid-frame.
REQ-022 SHALL handle i_Load in the boundary cycle as follows:
- the display takes the old pending data if r_Pending=1, otherwise stays unchanged;
- the new data goes to the pending registers;
- r_Pending ends at 1.
REQ-023 SHALL pulse o_Frame_Done for exactly one cycle on the cycle after each frame boundary edge, whether or not data was applied.
REQ-024 SHALL apply leading-zero blanking when the display blank flag is 1: digit k (k=3,2,1) is blanked if nibbles k..3 are all zero; digit 0 is never blanked.
REQ-025 SHALL keep o_Anode all high, o_Segment=7'h7F and o_Dp=1 during a blanked digit's DRIVE slot; slot timing is unchanged.

Reset
REQ-026 SHALL, while i_Rst=1 at a clock edge, set:
- FSM=BLANK, r_Count=0, r_Digit=0;
- r_Pending=0; display and pending registers all 0;
- o_Anode=4'b1111, o_Segment=7'h7F, o_Dp=1, o_Frame_Done=0.
REQ-027 SHALL discard any in-progress frame and pending load on reset; i_Load is ignored in the reset cycle.
REQ-028 SHALL, after reset release, start at digit 0 in BLANK and show 0000 (or only "0" if blanking was loaded).

Structure
REQ-029 SHALL place the FSM state encoding, the segment pattern constants and the all-off value 7'h7F in a shared package seg_pkg.
REQ-030 SHALL implement the decode as the combinational sub-module hex_to_7seg (4-bit in, 7-bit active-low out), instantiated once.

Verification (c_BLANK_LIMIT=2, c_REFRESH_LIMIT=5, frame=28 cycles)
REQ-031 Reset then no load -> anodes cycle 1110,1101,1011,0111 with 5-cycle low windows separated by 2-cycle 1111 gaps; segments 7'b1000000 in every window; o_Frame_Done every 28 cycles.
REQ-032 Load i_Value=16'h12F8, i_Dp=4'b0100 mid-frame -> current frame unchanged; next frame shows digit0=8 (0000000), digit1=F (0001110), digit2=2 with o_Dp=0, digit3=1 (1111001).
REQ-033 Load 16'h0005 with i_Blank_Lz=1 -> digits 3,2,1 keep anode high through their DRIVE slots; digit 0 shows 5; load 16'h0000 -> only digit 0 lit, showing 0.
REQ-034 Load A then load B in the same frame -> next frame shows B only; load C in the boundary cycle with B pending -> B shown next frame, C on the frame after.
REQ-035 Assert i_Rst during digit 2 DRIVE with a load pending -> next cycle all outputs at reset values; after release, digit 0 shows 0, the pending value is never displayed, and the first o_Frame_Done comes 28 cycles after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM states,
// active-low segment patterns ({g,f,e,d,c,b,a}) and all-off values.
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } seg_state_e;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_Hex,
  output logic [6:0] o_Seg
);

  always_comb begin
    o_Seg = SEG_OFF;
    case (i_Hex)
      4'h0: o_Seg = SEG_0;
      4'h1: o_Seg = SEG_1;
      4'h2: o_Seg = SEG_2;
      4'h3: o_Seg = SEG_3;
      4'h4: o_Seg = SEG_4;
      4'h5: o_Seg = SEG_5;
      4'h6: o_Seg = SEG_6;
      4'h7: o_Seg = SEG_7;
      4'h8: o_Seg = SEG_8;
      4'h9: o_Seg = SEG_9;
      4'hA: o_Seg = SEG_A;
      4'hB: o_Seg = SEG_B;
      4'hC: o_Seg = SEG_C;
      4'hD: o_Seg = SEG_D;
      4'hE: o_Seg = SEG_E;
      4'hF: o_Seg = SEG_F;
      default: o_Seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with anti-ghost blanking,
// frame-synchronous display updates and leading-zero suppression.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned c_REFRESH_LIMIT = 100000,
  parameter int unsigned c_BLANK_LIMIT   = 1000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Load,
  input  logic [15:0] i_Value,
  input  logic [3:0]  i_Dp,
  input  logic        i_Blank_Lz,
  output logic [3:0]  o_Anode,
  output logic [6:0]  o_Segment,
  output logic        o_Dp,
  output logic        o_Frame_Done
);

  localparam int unsigned CNT_MAX = (c_REFRESH_LIMIT > c_BLANK_LIMIT) ? c_REFRESH_LIMIT
                                                                       : c_BLANK_LIMIT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(c_BLANK_LIMIT - 1);
  localparam logic [CNT_W-1:0] DRIVE_END = CNT_W'(c_REFRESH_LIMIT - 1);

  seg_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       digit_q, digit_d;
  logic             boundary;

  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_blz_q, pend_blz_d;
  logic        pending_q, pending_d;
  logic [15:0] disp_val_q, disp_val_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic        disp_blz_q, disp_blz_d;

  logic [3:0] anode_q, anode_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       fdone_q, fdone_d;

  logic [15:0] upper_nibbles;
  logic [3:0]  cur_nibble;
  logic [6:0]  dec_seg;
  logic        lz_hide;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    digit_d    = digit_q;
    boundary   = 1'b0;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_blz_d = pend_blz_q;
    pending_d  = pending_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    disp_blz_d = disp_blz_q;

    unique case (state_q)
      ST_BLANK: begin
        if (count_q == BLANK_END) begin
          state_d = ST_DRIVE;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (count_q == DRIVE_END) begin
          state_d  = ST_BLANK;
          count_d  = '0;
          digit_d  = digit_q + 2'd1;
          boundary = (digit_q == 2'd3);
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        count_d = '0;
      end
    endcase

    // Boundary commit is evaluated before the load so that a load landing
    // on the boundary cycle becomes the next pending value, not the display.
    if (boundary && pending_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      disp_blz_d = pend_blz_q;
      pending_d  = 1'b0;
    end
    if (i_Load) begin
      pend_val_d = i_Value;
      pend_dp_d  = i_Dp;
      pend_blz_d = i_Blank_Lz;
      pending_d  = 1'b1;
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // FSM state they describe rather than lagging by a cycle.
  always_comb begin
    upper_nibbles = disp_val_d >> {digit_d, 2'b00};
    cur_nibble    = upper_nibbles[3:0];
    lz_hide       = disp_blz_d && (digit_d != 2'd0) && (upper_nibbles == 16'h0000);

    anode_d = ANODE_OFF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    if ((state_d == ST_DRIVE) && !lz_hide) begin
      anode_d = ~(4'b0001 << digit_d);
      seg_d   = dec_seg;
      dp_d    = ~disp_dp_d[digit_d];
    end
    fdone_d = boundary;
  end

  hex_to_7seg u_dec (
    .i_Hex (cur_nibble),
    .o_Seg (dec_seg)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_BLANK;
      count_q    <= '0;
      digit_q    <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_blz_q <= 1'b0;
      pending_q  <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      disp_blz_q <= 1'b0;
      anode_q    <= ANODE_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      digit_q    <= digit_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_blz_q <= pend_blz_d;
      pending_q  <= pending_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      disp_blz_q <= disp_blz_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fdone_q    <= fdone_d;
    end
  end

  assign o_Anode      = anode_q;
  assign o_Segment    = seg_q;
  assign o_Dp         = dp_q;
  assign o_Frame_Done = fdone_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-position reference model
// predicts every output cycle, a monitor compares against the DUT.
module tb_seg_scan_driver;

  localparam int unsigned BL    = 2;
  localparam int unsigned RL    = 5;
  localparam int unsigned SLOT  = BL + RL;
  localparam int unsigned FRAME = 4 * SLOT;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blz = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dp_out;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .c_REFRESH_LIMIT (RL),
    .c_BLANK_LIMIT   (BL)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Load       (load),
    .i_Value      (value),
    .i_Dp         (dp_in),
    .i_Blank_Lz   (blz),
    .o_Anode      (anode),
    .o_Segment    (segment),
    .o_Dp         (dp_out),
    .o_Frame_Done (frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } obs_t;

  obs_t exp_q[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference model: cycle position since reset plus frame-level data registers.
  int unsigned n = 0;
  logic [15:0] m_disp = '0, m_pv = '0;
  logic [3:0]  m_dd = '0, m_pd = '0;
  logic        m_db = 1'b0, m_pb = 1'b0, m_pend = 1'b0;

  function automatic obs_t predict();
    obs_t o;
    int unsigned r, pos, d, lead;
    logic [3:0] nib;
    r   = n % FRAME;
    pos = r % SLOT;
    d   = r / SLOT;
    o.an  = 4'b1111;
    o.seg = 7'h7F;
    o.dp  = 1'b1;
    o.fd  = (n != 0) && (r == 0);
    lead = 0;
    for (int i = 0; i < 4; i++)
      if (m_disp[4*i +: 4] != 4'h0) lead = i;
    if (pos >= BL && !(m_db && d > lead)) begin
      nib = m_disp[4*d +: 4];
      o.an[d] = 1'b0;
      o.seg = SEG_TBL[nib];
      o.dp = ~m_dd[d];
    end
    return o;
  endfunction

  task automatic step(input logic r_in, input logic ld, input logic [15:0] v,
                      input logic [3:0] d_in, input logic b_in);
    @(negedge clk);
    rst = r_in; load = ld; value = v; dp_in = d_in; blz = b_in;
    @(posedge clk);
    if (r_in) begin
      n = 0;
      m_disp = '0; m_dd = '0; m_db = 1'b0;
      m_pv = '0; m_pd = '0; m_pb = 1'b0; m_pend = 1'b0;
    end else begin
      n++;
      if ((n % FRAME) == 0 && m_pend) begin
        m_disp = m_pv; m_dd = m_pd; m_db = m_pb; m_pend = 1'b0;
      end
      if (ld) begin
        m_pv = v; m_pd = d_in; m_pb = b_in; m_pend = 1'b1;
      end
    end
    exp_q.push_back(predict());
  endtask

  task automatic idle(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Advance until the next edge lands on frame position t.
  task automatic align(input int unsigned t);
    for (int unsigned i = 0; i < FRAME && ((n + 1) % FRAME) != t; i++)
      step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d_in, input logic b_in);
    step(1'b0, 1'b1, v, d_in, b_in);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{an: anode, seg: segment, dp: dp_out, fd: frame_done};
        total++;
        if (a === e) passed++;
        else $display("FAIL outputs t=%0t: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                      $time, a.an, a.seg, a.dp, a.fd, e.an, e.seg, e.dp, e.fd);
      end
    end
  end

  initial begin : stimulus
    step(1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 16'h9999, 4'hF, 1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    idle(70);

    align(10);
    do_load(16'h12F8, 4'b0100, 1'b0);
    idle(70);

    do_load(16'h0005, 4'b0000, 1'b1);
    idle(60);
    do_load(16'h0000, 4'b0000, 1'b1);
    idle(60);

    align(3);
    do_load(16'hABCD, 4'b0001, 1'b0);
    idle(4);
    do_load(16'h0B0E, 4'b0010, 1'b1);
    align(0);
    do_load(16'h3C07, 4'b1000, 1'b0);
    idle(60);

    do_load(16'h7777, 4'b1111, 1'b0);
    align(16);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    idle(70);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
           16'($urandom), 4'($urandom), 1'($urandom));
    end
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
